cm_page_buffer: RTL and testbench

Double-buffered (ping-pong) candidate-match memory for the tracklet processing pipeline. Accepts a stream of 12-bit match words per bunch crossing (BX), stores them in a register-array page chosen by BX parity, and reports the number of words written. A downstream reader drains the opposite page through a registered read port. A fixed-length delay pipe regenerates the start/done handshake for the next stage.

---
 rtl/cm_page_buffer.sv | 94 +++++++++
 tb/tb_cm_page_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cm_page_buffer.sv
// Ping-pong candidate-match page buffer. Incoming words are written into the page chosen by BX parity,
// the opposite page is drained through a registered read port, and start is echoed as done after TMUX cycles.
module cm_page_buffer #(
  parameter int MEM_SIZE   = 5,
  parameter int TMUX       = 6,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [1:0]            start,
  output logic [1:0]            done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
  output logic [MEM_SIZE:0]     number_out,
  input  logic [MEM_SIZE+2:0]   read_add,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** (MEM_SIZE + 1);

  logic [TMUX-1:0][1:0]  pipe;
  logic [2:0]            bx;
  logic                  first_clk;
  logic [MEM_SIZE:0]     wr_add;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_dly;
  logic [MEM_SIZE:0]     read_add_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [MEM_SIZE:0]     wr_addr;

  // en_proc and the upper read address bits are part of the pipeline interface but carry no function here.
  logic unused_bits;
  assign unused_bits = ^{en_proc, read_add[MEM_SIZE+2:MEM_SIZE+1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[TMUX-2:0], start};
  end

  assign done = pipe[TMUX-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx        <= 3'b111;
      first_clk <= 1'b0;
    end else begin
      if (start[1])      bx <= 3'b111;
      else if (start[0]) bx <= bx + 3'd1;
      first_clk <= start[0] & ~start[1];
    end
  end

  // wr_add idles at all ones so that the first accepted word after a new BX lands at offset 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_add     <= '1;
      wr_en      <= 1'b0;
      number_out <= '0;
      data_dly   <= '0;
    end else if (first_clk) begin
      number_out <= wr_add + 1'b1;
      wr_add     <= '1;
      wr_en      <= 1'b0;
    end else begin
      data_dly <= data_in;
      if (enable) begin
        wr_add <= wr_add + 1'b1;
        wr_en  <= 1'b1;
      end else begin
        wr_en  <= 1'b0;
      end
    end
  end

  assign wr_addr = {bx[0], wr_add[MEM_SIZE-1:0]};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_dly;
  end

  // Registered address plus output register; start[1] flushes the output but never the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_add_reg <= '0;
      data_out     <= '0;
    end else begin
      read_add_reg <= read_add[MEM_SIZE:0];
      if (start[1]) data_out <= '0;
      else          data_out <= mem[read_add_reg];
    end
  end

endmodule

// File: tb/tb_cm_page_buffer.sv
// Directed bench for cm_page_buffer: a per-BX word-count/memory model checked every cycle,
// plus hand-computed expectations at the interesting points.
module tb_cm_page_buffer;
  localparam int MS = 5;
  localparam int TM = 6;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en_proc = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [1:0]    done;
  logic [DW-1:0] data_in = '0;
  logic          enable = 1'b0;
  logic [MS:0]   number_out;
  logic [MS+2:0] read_add = '0;
  logic [DW-1:0] data_out;

  cm_page_buffer #(.MEM_SIZE(MS), .TMUX(TM), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done),
    .data_in(data_in), .enable(enable), .number_out(number_out),
    .read_add(read_add), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Model: words counted per BX, memory image with writes landing one edge after acceptance.
  logic [DW-1:0] m_mem [64];
  logic [1:0]    slog [4096];
  int            cnt, cyc;
  logic [2:0]    m_bx;
  logic          m_first, m_pv;
  logic [5:0]    m_pa, m_ra;
  logic [DW-1:0] m_pd;
  logic [1:0]    e_done;
  logic [5:0]    e_num;
  logic [DW-1:0] e_dout;

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      cnt = 0; cyc = 0; m_bx = 3'b111; m_first = 1'b0; m_pv = 1'b0; m_ra = '0;
      e_done = 2'b00; e_num = '0; e_dout = '0;
    end else begin
      slog[cyc % 4096] = start;
      e_done = (cyc >= TM - 1) ? slog[(cyc - (TM - 1)) % 4096] : 2'b00;
      cyc++;
      e_dout = start[1] ? '0 : m_mem[m_ra];
      m_ra = read_add[MS:0];
      if (m_pv) m_mem[m_pa] = m_pd;
      if (start[1])      m_bx = 3'b111;
      else if (start[0]) m_bx = m_bx + 3'd1;
      if (m_first) begin
        e_num = 6'(cnt);
        cnt = 0;
        m_pv = 1'b0;
      end else if (enable) begin
        cnt++;
        m_pv = 1'b1;
        m_pa = {m_bx[0], 5'(cnt - 1)};
        m_pd = data_in;
      end else begin
        m_pv = 1'b0;
      end
      m_first = start[0] & ~start[1];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_number_out", 32'(number_out), 32'(e_num));
      check("cyc_data_out", 32'(data_out), 32'(e_dout));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] v);
    start = v;
    @(negedge clk);
    start = 2'b00;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    enable = 1'b1;
    data_in = d;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input logic [DW-1:0] exp_v);
    read_add = 7'(addr);
    idle(2);
    check(name, 32'(data_out), 32'(exp_v));
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("reset_done", 32'(done), 0);
    check("reset_number_out", 32'(number_out), 0);
    check("reset_data_out", 32'(data_out), 0);

    idle(2);
    pulse_start(2'b01);
    idle(4);
    check("done_before_tmux", 32'(done), 0);
    idle(1);
    check("done_at_tmux", 32'(done), 1);
    idle(1);
    check("done_after_tmux", 32'(done), 0);

    write_word(12'h111);
    write_word(12'h222);
    write_word(12'h333);
    idle(2);
    pulse_start(2'b01);
    idle(2);
    check("num_three", 32'(number_out), 3);
    read_chk("rd_p0_0", 0, 12'h111);
    read_chk("rd_p0_1", 1, 12'h222);
    read_chk("rd_p0_2", 2, 12'h333);

    write_word(12'hAAA);
    idle(2);
    pulse_start(2'b01);
    idle(2);
    check("num_one", 32'(number_out), 1);
    read_chk("rd_p1_0", 32, 12'hAAA);
    read_chk("rd_p0_intact", 0, 12'h111);

    pulse_start(2'b01);
    idle(2);
    check("num_zero", 32'(number_out), 0);

    for (int i = 0; i < 33; i++) write_word(12'(12'h100 + i));
    idle(2);
    pulse_start(2'b01);
    write_word(12'hBAD);
    write_word(12'h055);
    write_word(12'h066);
    idle(1);
    check("num_wrap33", 32'(number_out), 33);
    read_chk("rd_wrap_off0", 32, 12'h120);
    read_chk("rd_wrap_off1", 33, 12'h101);
    pulse_start(2'b01);
    idle(2);
    check("num_dropped", 32'(number_out), 2);
    read_chk("rd_after_drop0", 0, 12'h055);
    read_chk("rd_after_drop1", 1, 12'h066);

    write_word(12'h0EE);
    idle(1);
    pulse_start(2'b11);
    check("sync_clear_dout", 32'(data_out), 0);
    idle(1);
    pulse_start(2'b01);
    idle(1);
    write_word(12'h777);
    idle(2);
    read_chk("rd_bx_rewound", 0, 12'h777);
    check("num_after_sync", 32'(number_out), 1);

    enable = 1'b1;
    data_in = 12'h999;
    #2 reset = 1'b1;
    #1;
    check("async_done", 32'(done), 0);
    check("async_number_out", 32'(number_out), 0);
    check("async_data_out", 32'(data_out), 0);
    @(negedge clk);
    enable = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(2);
    check("post_reset_num", 32'(number_out), 0);
    read_chk("mem_survives_reset", 0, 12'h777);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
